// File: rtl/fpu_issue_queue.sv
// Issue stage for the half-precision fpu: buffers requests, tracks its one-cycle
// registered latency with a tagged valid pipeline and returns results in request order.
module fpu_issue_queue #(
   parameter int QDEPTH = 4,
   parameter int RDEPTH = 4,
   parameter int TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [15:0]      req_a,
   input  logic [15:0]      req_b,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic [15:0]      fpu_a,
   output logic [15:0]      fpu_b,
   output logic [1:0]       fpu_opcode,
   input  logic [15:0]      fpu_out,
   input  logic [5:0]       fpu_flag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_result,
   output logic [5:0]       rsp_flag,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [3:0]       sticky_flag,
   input  logic             sticky_clr,
   output logic [1:0]       inflight
);

   localparam int QW = $clog2(QDEPTH);
   localparam int RW = $clog2(RDEPTH);

   logic [15:0]      q_a   [QDEPTH];
   logic [15:0]      q_b   [QDEPTH];
   logic [1:0]       q_op  [QDEPTH];
   logic [TAG_W-1:0] q_tag [QDEPTH];
   logic [QW-1:0]    q_wr;
   logic [QW-1:0]    q_rd;
   logic [QW:0]      q_count;

   logic [15:0]      rb_res [RDEPTH];
   logic [5:0]       rb_flg [RDEPTH];
   logic [TAG_W-1:0] rb_tag [RDEPTH];
   logic [RW-1:0]    rb_wr;
   logic [RW-1:0]    rb_rd;
   logic [RW:0]      rb_count;

   logic             s1_v;
   logic             s2_v;
   logic [1:0]       s1_op;
   logic [1:0]       s2_op;
   logic [TAG_W-1:0] s1_tag;
   logic [TAG_W-1:0] s2_tag;
   logic [3:0]       sticky;

   logic             push;
   logic             issue;
   logic             pop;
   logic             capture;
   logic [RW+1:0]    occ;
   logic [QW:0]      q_count_nx;
   logic [RW:0]      rb_count_nx;
   logic [15:0]      cap_res;
   logic [5:0]       cap_flg;
   logic [3:0]       sticky_nx;

   always_comb begin
      push        = req_valid && req_ready;
      pop         = (rb_count != (RW+1)'(0)) && rsp_ready;
      capture     = s2_v;
      // credit counts results already buffered plus everything still in the fpu
      occ         = (RW+2)'(rb_count) + (RW+2)'(s1_v) + (RW+2)'(s2_v);
      issue       = (q_count != (QW+1)'(0)) && (occ < (RW+2)'(RDEPTH));
      q_count_nx  = q_count + (QW+1)'(push) - (QW+1)'(issue);
      rb_count_nx = rb_count + (RW+1)'(capture) - (RW+1)'(pop);
      if (s2_op == 2'b11) begin
         cap_res = 16'h7E00;
         cap_flg = 6'b010000;
      end else begin
         cap_res = fpu_out;
         cap_flg = fpu_flag;
      end
      if (capture) begin
         sticky_nx = (sticky_clr ? 4'b0000 : sticky) |
                     {(s2_op == 2'b11), cap_flg[5], cap_flg[4], cap_flg[3]};
      end else if (sticky_clr) begin
         sticky_nx = 4'b0000;
      end else begin
         sticky_nx = sticky;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_a[q_wr]   <= req_a;
         q_b[q_wr]   <= req_b;
         q_op[q_wr]  <= req_op;
         q_tag[q_wr] <= req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_wr      <= QW'(0);
         q_rd      <= QW'(0);
         q_count   <= (QW+1)'(0);
         req_ready <= 1'b0;
      end else begin
         if (push) begin
            q_wr <= q_wr + QW'(1);
         end
         if (issue) begin
            q_rd <= q_rd + QW'(1);
         end
         q_count   <= q_count_nx;
         req_ready <= (q_count_nx < (QW+1)'(QDEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpu_a      <= 16'h0000;
         fpu_b      <= 16'h0000;
         fpu_opcode <= 2'b00;
         s1_v       <= 1'b0;
         s2_v       <= 1'b0;
         s1_op      <= 2'b00;
         s2_op      <= 2'b00;
         s1_tag     <= TAG_W'(0);
         s2_tag     <= TAG_W'(0);
      end else begin
         if (issue) begin
            fpu_a      <= q_a[q_rd];
            fpu_b      <= q_b[q_rd];
            fpu_opcode <= q_op[q_rd];
            s1_op      <= q_op[q_rd];
            s1_tag     <= q_tag[q_rd];
         end
         s1_v   <= issue;
         s2_v   <= s1_v;
         s2_op  <= s1_op;
         s2_tag <= s1_tag;
      end
   end

   // result buffer is cleared on reset so the head reads zero while empty
   always_ff @(posedge clk) begin
      if (rst) begin
         rb_wr    <= RW'(0);
         rb_rd    <= RW'(0);
         rb_count <= (RW+1)'(0);
         for (int i = 0; i < RDEPTH; i++) begin
            rb_res[i] <= 16'h0000;
            rb_flg[i] <= 6'b000000;
            rb_tag[i] <= TAG_W'(0);
         end
      end else begin
         if (capture) begin
            rb_res[rb_wr] <= cap_res;
            rb_flg[rb_wr] <= cap_flg;
            rb_tag[rb_wr] <= s2_tag;
            rb_wr         <= rb_wr + RW'(1);
         end
         if (pop) begin
            rb_rd <= rb_rd + RW'(1);
         end
         rb_count <= rb_count_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky <= 4'b0000;
      end else begin
         sticky <= sticky_nx;
      end
   end

   assign rsp_valid   = (rb_count != (RW+1)'(0));
   assign rsp_result  = rb_res[rb_rd];
   assign rsp_flag    = rb_flg[rb_rd];
   assign rsp_tag     = rb_tag[rb_rd];
   assign sticky_flag = sticky;
   assign inflight    = {1'b0, s1_v} + {1'b0, s2_v};

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue with a stand-in registered fpu and a result scoreboard.
module tb_fpu_issue_queue;

   localparam int QDEPTH = 4;
   localparam int RDEPTH = 4;
   localparam int TAG_W  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [1:0]  req_op;
   logic [3:0]  req_tag;
   logic [15:0] fpu_a;
   logic [15:0] fpu_b;
   logic [1:0]  fpu_opcode;
   logic [15:0] fpu_out;
   logic [5:0]  fpu_flag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [5:0]  rsp_flag;
   logic [3:0]  rsp_tag;
   logic [3:0]  sticky_flag;
   logic        sticky_clr;
   logic [1:0]  inflight;

   logic [25:0] sb[$];
   int          pop_cyc[$];
   int          cyc = 0;
   int          passed = 0;
   int          failed = 0;
   bit          acc;

   always #5 clk = ~clk;

   fpu_issue_queue #(.QDEPTH(QDEPTH), .RDEPTH(RDEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode),
      .fpu_out(fpu_out), .fpu_flag(fpu_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_tag(rsp_tag),
      .sticky_flag(sticky_flag), .sticky_clr(sticky_clr), .inflight(inflight)
   );

   // Known half-precision cases; anything else gets an arbitrary but deterministic answer.
   function automatic logic [21:0] fpu_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] op);
      if (a == 16'h3C00 && b == 16'h4000 && op == 2'b00) return {16'h4200, 6'b000001};
      if (a == 16'h4000 && b == 16'h4200 && op == 2'b10) return {16'h4600, 6'b000001};
      if (a == 16'h3C00 && b == 16'h3C00 && op == 2'b01) return {16'h0000, 6'b000100};
      if (a == 16'h7BFF && b == 16'h7BFF && op == 2'b00) return {16'h7C00, 6'b001000};
      if (a == 16'h7D00 && b == 16'h3C00 && op == 2'b00) return {16'h7F00, 6'b100000};
      return {a + b + {14'h0000, op}, 6'b000001};
   endfunction

   function automatic logic [25:0] expect_of(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] op, input logic [3:0] tag);
      logic [21:0] r;
      if (op == 2'b11) r = {16'h7E00, 6'b010000};
      else             r = fpu_model(a, b, op);
      return {r, tag};
   endfunction

   always @(posedge clk) begin
      {fpu_out, fpu_flag} <= fpu_model(fpu_a, fpu_b, fpu_opcode);
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Observe handshakes at the falling edge, then advance past the next rising edge.
   task automatic tick();
      logic [25:0] e;
      @(negedge clk);
      acc = req_valid && req_ready;
      if (acc) sb.push_back(expect_of(req_a, req_b, req_op, req_tag));
      if (rsp_valid === 1'b1 && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("rsp_result", 32'(rsp_result), 32'(e[25:10]));
            chk("rsp_flag",   32'(rsp_flag),   32'(e[9:4]));
            chk("rsp_tag",    32'(rsp_tag),    32'(e[3:0]));
            pop_cyc.push_back(cyc);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input logic [3:0] tag);
      int n = 0;
      req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
      do begin
         tick();
         n++;
      end while (!acc && n < 20);
      chk("send_accepted", 32'(acc), 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   k;
      logic seen;
      rst = 1'b1; req_valid = 1'b0; req_a = 16'h0000; req_b = 16'h0000; req_op = 2'b00;
      req_tag = 4'h0; rsp_ready = 1'b0; sticky_clr = 1'b0;
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_fpu_a", 32'(fpu_a), 32'd0);
      chk("rst_fpu_b", 32'(fpu_b), 32'd0);
      chk("rst_fpu_opcode", 32'(fpu_opcode), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", 32'(rsp_result), 32'd0);
      chk("rst_rsp_flag", 32'(rsp_flag), 32'd0);
      chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      chk("rst_sticky", 32'(sticky_flag), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      // single add with latency profile
      rsp_ready = 1'b1;
      req_a = 16'h3C00; req_b = 16'h4000; req_op = 2'b00; req_tag = 4'h5; req_valid = 1'b1;
      tick();
      chk("add_accepted", 32'(acc), 32'd1);
      req_valid = 1'b0;
      chk("lat_t0_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("lat_t1_valid", 32'(rsp_valid), 32'd0);
      chk("lat_t1_inflight", 32'(inflight), 32'd1);
      chk("lat_t1_fpu_a", 32'(fpu_a), 32'h3C00);
      chk("lat_t1_fpu_b", 32'(fpu_b), 32'h4000);
      tick();
      chk("lat_t2_valid", 32'(rsp_valid), 32'd0);
      chk("lat_t2_inflight", 32'(inflight), 32'd1);
      tick();
      chk("lat_t3_valid", 32'(rsp_valid), 32'd1);
      chk("lat_t3_inflight", 32'(inflight), 32'd0);
      drain(10);

      // back-to-back stream
      pop_cyc.delete();
      send(16'h4000, 16'h4200, 2'b10, 4'h1);
      send(16'h3C00, 16'h3C00, 2'b01, 4'h2);
      send(16'h7BFF, 16'h7BFF, 2'b00, 4'h3);
      drain(20);
      chk("stream_pops", 32'(pop_cyc.size()), 32'd3);
      if (pop_cyc.size() == 3) begin
         chk("stream_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
         chk("stream_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
      end
      chk("stream_sticky", 32'(sticky_flag), 32'h1);

      // backpressure: fill result buffer and request FIFO
      rsp_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 24; c++) begin
         req_valid = (k < 10);
         req_a = 16'h1000 + 16'(k); req_b = 16'h0100; req_op = 2'b00; req_tag = 4'(k);
         tick();
         if (acc) k++;
      end
      chk("bp_accepted", 32'(k), 32'd8);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_inflight", 32'(inflight), 32'd0);
      chk("bp_fpu_a_held", 32'(fpu_a), 32'h1003);
      req_valid = 1'b0;

      // pop alone, then pop and capture on the same edge at high occupancy
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      chk("refill_inflight", 32'(inflight), 32'd1);
      tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("conc_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();
      chk("conc_count_issue", 32'(inflight), 32'd1);
      chk("conc_fpu_a", 32'(fpu_a), 32'h1005);
      tick();
      tick();
      tick();
      chk("full_no_issue", 32'(inflight), 32'd0);
      chk("full_fpu_a_held", 32'(fpu_a), 32'h1005);

      rsp_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         req_valid = (k < 10);
         req_a = 16'h1000 + 16'(k); req_b = 16'h0100; req_op = 2'b00; req_tag = 4'(k);
         tick();
         if (acc) k++;
      end
      req_valid = 1'b0;
      drain(20);
      chk("bp_all_accepted", 32'(k), 32'd10);
      chk("bp_drained_valid", 32'(rsp_valid), 32'd0);

      // divide and sticky clear
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      chk("sticky_cleared", 32'(sticky_flag), 32'h0);
      send(16'h4000, 16'h3C00, 2'b11, 4'h9);
      drain(10);
      chk("div_sticky", 32'(sticky_flag), 32'hA);
      req_a = 16'h7D00; req_b = 16'h3C00; req_op = 2'b00; req_tag = 4'hC; req_valid = 1'b1;
      tick();
      chk("snan_accepted", 32'(acc), 32'd1);
      req_valid = 1'b0;
      tick();
      tick();
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      chk("clr_with_capture", 32'(sticky_flag), 32'h4);
      drain(10);

      // reset with operations in flight
      rsp_ready = 1'b0;
      send(16'h2000, 16'h2100, 2'b00, 4'h1);
      send(16'h2200, 16'h2300, 2'b10, 4'h2);
      send(16'h2400, 16'h2500, 2'b01, 4'h3);
      rst = 1'b1;
      tick();
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_inflight", 32'(inflight), 32'd0);
      chk("mid_rst_fpu_a", 32'(fpu_a), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_sticky", 32'(sticky_flag), 32'd0);
      chk("mid_rst_rsp_result", 32'(rsp_result), 32'd0);
      sb.delete();
      rst = 1'b0;
      rsp_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      chk("flushed_no_rsp", 32'(seen), 32'd0);
      chk("post_flush_req_ready", 32'(req_ready), 32'd1);

      $display("%0d/%0d checks passed", passed, passed + failed);
      $finish;
   end

endmodule
